pulse_rate_scheduler: RTL and testbench

//  Shares one rate-limited pulse generator (a cooldown counter) between NUM_REQ request lines.

---
 rtl/pulse_rate_scheduler_pkg.sv | 18 +
 rtl/pulse_rate_scheduler_if.sv | 30 +++
 rtl/pulse_rate_scheduler_rr_pick.sv | 27 ++
 rtl/pulse_rate_scheduler.sv | 108 ++++++++++
 tb/tb_pulse_rate_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_rate_scheduler_pkg.sv
// Shared types and helpers for the pulse rate scheduler.
// STICKY option: define PULSE_RATE_SCHEDULER_STICKY_EN.
package pulse_rate_scheduler_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COOL = 1'b1
    } state_e;

    // Instantiators size IDX_W with this.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/pulse_rate_scheduler_if.sv
// Request/pulse bundle between requesters and the scheduler.
// Slave side is the scheduler; master side drives requests.
interface pulse_rate_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) ();

    logic               enable;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pulse_out;
    logic [IDX_W-1:0]   grant_idx;
    logic               busy;

    modport master (
        output enable,
        output req,
        input  pulse_out,
        input  grant_idx,
        input  busy
    );

    modport slave (
        input  enable,
        input  req,
        output pulse_out,
        output grant_idx,
        output busy
    );

endinterface

// File: rtl/pulse_rate_scheduler_rr_pick.sv
// Combinational round-robin pick: first set bit searching upward
// from last+1, wrapping.
module pulse_rate_scheduler_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   pick
);

    logic [IDX_W-1:0] idx;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IDX_W'((int'(last) + i) % NUM_REQ);
            if (eligible[idx]) pick = idx;
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/pulse_rate_scheduler.sv
// Round-robin sharing of one cooldown pulse generator among NUM_REQ lines.
// Optional PULSE_RATE_SCHEDULER_STICKY_EN latches request rising edges.
module pulse_rate_scheduler
    import pulse_rate_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int COOLDOWN_BITS = 21,
    parameter int IDX_W         = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pulse_rate_scheduler_if.slave bus
);

    state_e                   state_q, state_d;
    logic [COOLDOWN_BITS-1:0] count_q, count_d;
    logic [NUM_REQ-1:0]       pulse_q, pulse_d;
    logic [IDX_W-1:0]         grant_q, grant_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic                     busy_q, busy_d;

    logic [NUM_REQ-1:0] eligible;
    logic               any;
    logic [IDX_W-1:0]   pick;

`ifdef PULSE_RATE_SCHEDULER_STICKY_EN
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] pending_q, pending_d;

    assign eligible = pending_q | bus.req;
`else
    assign eligible = bus.req;
`endif

    pulse_rate_scheduler_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .eligible (eligible),
        .last     (last_q),
        .any      (any),
        .pick     (pick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = '0;
        grant_d = grant_q;
        last_d  = last_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.enable && any) begin
                    state_d = ST_COOL;
                    count_d = COOLDOWN_BITS'(1);
                    pulse_d = NUM_REQ'(1) << pick;
                    grant_d = pick;
                    last_d  = pick;
                    busy_d  = 1'b1;
                end
            end
            ST_COOL: begin
                count_d = count_q + 1'b1;
                // All-ones is the last cooldown cycle; count wraps to 0.
                if (&count_q) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

`ifdef PULSE_RATE_SCHEDULER_STICKY_EN
    assign pending_d = (pending_q | (bus.req & ~req_q)) & ~pulse_d;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pulse_q   <= '0;
            grant_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            busy_q    <= 1'b0;
`ifdef PULSE_RATE_SCHEDULER_STICKY_EN
            req_q     <= '0;
            pending_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pulse_q   <= pulse_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
`ifdef PULSE_RATE_SCHEDULER_STICKY_EN
            req_q     <= bus.req;
            pending_q <= pending_d;
`endif
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.grant_idx = grant_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pulse_rate_scheduler.sv
// Scoreboard bench for pulse_rate_scheduler, NUM_REQ=4, COOLDOWN_BITS=4.
// Expected pulses are queued with their cycle; a monitor pops them.
module tb_pulse_rate_scheduler;

    localparam int N  = 4;
    localparam int CB = 4;
    localparam int P  = 16;
    localparam int IW = pulse_rate_scheduler_pkg::clog2(N);

    typedef struct {
        int           cyc;
        logic [N-1:0] pulse;
        logic [IW-1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   sb_on = 1'b1;
    bit   rand_on = 1'b0;
    int   last_pulse = -1000;
    int   pcount = 0;
    int   wait_cnt [N];
    exp_t q [$];

    pulse_rate_scheduler_if #(.NUM_REQ(N), .IDX_W(IW)) bus ();

    pulse_rate_scheduler #(
        .NUM_REQ       (N),
        .COOLDOWN_BITS (CB),
        .IDX_W         (IW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every observed pulse must match the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (sb_on && bus.pulse_out !== '0) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected cyc=%0d got pulse=%b idx=%0d, want no pulse",
                         cyc, bus.pulse_out, bus.grant_idx);
            end else begin
                e = q.pop_front();
                if (bus.pulse_out !== e.pulse || bus.grant_idx !== e.idx || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL sb_pulse got cyc=%0d pulse=%b idx=%0d, want cyc=%0d pulse=%b idx=%0d",
                             cyc, bus.pulse_out, bus.grant_idx, e.cyc, e.pulse, e.idx);
                end
            end
        end
    end

    // Invariant checker for the randomised run.
    always @(negedge clk) begin
        if (rand_on) begin
            if (bus.pulse_out !== '0) begin
                pcount++;
                checks++;
                if (!$onehot(bus.pulse_out)) begin
                    errors++;
                    $display("FAIL rand_onehot cyc=%0d got %b want one-hot", cyc, bus.pulse_out);
                end
                checks++;
                if (cyc - last_pulse < P) begin
                    errors++;
                    $display("FAIL rand_spacing cyc=%0d got gap %0d want >= %0d",
                             cyc, cyc - last_pulse, P);
                end
                last_pulse = cyc;
            end
            for (int i = 0; i < N; i++) begin
                if (bus.pulse_out[i] === 1'b1) wait_cnt[i] = 0;
                else if (bus.req[i] && bus.enable) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                checks++;
                if (wait_cnt[i] > 4 * P + 2) begin
                    errors++;
                    $display("FAIL rand_starve req%0d cyc=%0d got wait %0d want <= %0d",
                             i, cyc, wait_cnt[i], 4 * P + 2);
                    wait_cnt[i] = 0;
                end
            end
        end
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.req = '0;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.pulse_out !== '0) begin
            errors++;
            $display("FAIL reset_pulse got %b want 0000", bus.pulse_out);
        end
        checks++;
        if (bus.grant_idx !== '0) begin
            errors++;
            $display("FAIL reset_idx got %0d want 0", bus.grant_idx);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
    endtask

    task automatic test_single();
        int c0;
        bit ok;
        logic exp_busy;
        c0 = cyc;
        reset_n = 1'b1;
        bus.req = 4'b0001;
        for (int k = 0; k < 3; k++) q.push_back(exp_t'{c0 + 1 + P * k, 4'b0001, 2'd0});
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            exp_busy = ((j - 1) % P) < (P - 1);
            checks++;
            if (bus.busy !== exp_busy) begin
                errors++;
                $display("FAIL single_busy j=%0d got %b want %b", j, bus.busy, exp_busy);
            end
        end
        bus.req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_idle got busy stuck want idle");
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL single_missing got %0d pending pulses want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_rotation();
        int c0;
        bit ok;
        reset_n = 1'b0;
        @(negedge clk);
        c0 = cyc;
        reset_n = 1'b1;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++)
            q.push_back(exp_t'{c0 + 1 + P * k, 4'(1 << (k % N)), 2'(k % N)});
        repeat (70) @(negedge clk);
        bus.req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rot_idle got busy stuck want idle");
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rot_missing got %0d pending pulses want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_cool_drop();
        int c0;
        bit ok;
        c0 = cyc;
        bus.req = 4'b0001;
        q.push_back(exp_t'{c0 + 1, 4'b0001, 2'd0});
        @(negedge clk);
        bus.req = '0;
        repeat (4) @(negedge clk);
        bus.req = 4'b0100;
        repeat (2) @(negedge clk);
        bus.req = '0;
`ifdef PULSE_RATE_SCHEDULER_STICKY_EN
        q.push_back(exp_t'{c0 + P + 1, 4'b0100, 2'd2});
`endif
        repeat (30) @(negedge clk);
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drop_idle got busy stuck want idle");
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drop_missing got %0d pending pulses want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_enable();
        int c0;
        bit ok;
        c0 = cyc;
        bus.enable = 1'b0;
        bus.req = 4'b0010;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL en_busy j=%0d got %b want 0", j, bus.busy);
            end
        end
        bus.enable = 1'b1;
        q.push_back(exp_t'{c0 + 21, 4'b0010, 2'd1});
        @(negedge clk);
        bus.req = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL en_cool got busy=%b want 1", bus.busy);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL en_idle got busy stuck want idle");
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL en_missing got %0d pending pulses want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        bit ok;
        c0 = cyc;
        bus.req = 4'b0010;
        q.push_back(exp_t'{c0 + 1, 4'b0010, 2'd1});
        @(negedge clk);
        bus.req = 4'b0001;
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pulse_out !== '0) begin
            errors++;
            $display("FAIL rmid_pulse got %b want 0000", bus.pulse_out);
        end
        checks++;
        if (bus.grant_idx !== '0) begin
            errors++;
            $display("FAIL rmid_idx got %0d want 0", bus.grant_idx);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_busy got %b want 0", bus.busy);
        end
        reset_n = 1'b1;
        q.push_back(exp_t'{c0 + 9, 4'b0001, 2'd0});
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_regrant got busy=%b want 1", bus.busy);
        end
        bus.req = '0;
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rmid_idle got busy stuck want idle");
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rmid_missing got %0d pending pulses want 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_random();
        int b;
        sb_on = 1'b0;
        last_pulse = -1000;
        pcount = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        rand_on = 1'b1;
        for (int t = 0; t < 10000; t++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 31) == 0) begin
                b = $urandom_range(0, N - 1);
                bus.req[b] = ~bus.req[b];
            end
            if (bus.enable) begin
                if ($urandom_range(0, 199) == 0) bus.enable = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.enable = 1'b1;
            end
        end
        @(negedge clk);
        rand_on = 1'b0;
        bus.req = '0;
        bus.enable = 1'b1;
        checks++;
        if (pcount < 100) begin
            errors++;
            $display("FAIL rand_activity got %0d pulses want >= 100", pcount);
        end
    endtask

    initial begin
        bus.req = '0;
        bus.enable = 1'b1;
        test_reset();
        test_single();
        test_rotation();
        test_cool_drop();
        test_enable();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got no completion want finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
